morse_timer_sched: RTL and testbench
====================================

// Module: morse_timer_sched
// PURPOSE
//   Shares one 100 ms tick-driven countdown between two requesters of the Morse game:
//   req 0 = symbol playback (dot/dash/gap on LED), req 1 = player input window.
//   Arbitrates requests round-robin, loads the winner's duration (in 100 ms units),
//   counts HundredmsTimeOut pulses and returns a done pulse to the owner. Sits between
//   the 100 ms prescaler and the game FSMs.
// PARAMETERS
//   CNT_W   6   width of duration/remaining count (max 63 ticks = 6.3 s)
// PORTS
//   clk               in   1      system clock, all state on posedge
//   rst               in   1      asynchronous active-low reset
//   HundredmsTimeOut  in   1      1-cycle tick every 100 ms
//   req               in   2      level request per requester, held until gnt
//   dur0              in   CNT_W  requester 0 duration, sampled at grant
//   dur1              in   CNT_W  requester 1 duration, sampled at grant
//   cancel            in   2      abort own running timeout (only owner's bit acts)
//   pause             in   1      freeze countdown (present only with MORSE_TIMER_PAUSE_EN)
//   gnt               out  2      1-cycle grant pulse, one-hot
//   done              out  2      1-cycle timeout pulse to owner, one-hot
//   busy              out  1      high in RUN and DONE
//   owner             out  1      index of current/last owner
//   remaining         out  CNT_W  ticks left in RUN, 0 otherwise
// BEHAVIOUR
//   - Reset (rst=0, async): state=IDLE, gnt=0, done=0, busy=0, owner=0, remaining=0,
//     rr pointer=0 (requester 0 preferred on first tie).
//   - States IDLE, RUN, DONE; all outputs registered.
//   - IDLE: req!=0 -> grant one; both set -> grant index==rr, then rr<=~granted.
//     Single request -> granted regardless of rr; rr<=~granted. Next cycle: RUN,
//     gnt[i]=1 for exactly that cycle, owner=i, remaining=dur_i (dur_i==0 loads 1).
//   - Ticks seen in IDLE or on the grant cycle are ignored; first countable tick is
//     the cycle after gnt.
//   - RUN: tick -> remaining-1. Tick with remaining==1 -> DONE next cycle, remaining=0.
//   - DONE: done[owner]=1 for one cycle, busy=1; then IDLE, busy=0. Requests held
//     during RUN/DONE wait; earliest next gnt is 2 cycles after done.
//   - Latency: req in IDLE at cycle N -> gnt at N+1; final tick at cycle M -> done at M+1.
//     Duration D -> done after D ticks following the grant.
//   - cancel[owner] in RUN -> IDLE next cycle, remaining=0, no done; cancel wins over a
//     simultaneous final tick. cancel of non-owner, or in IDLE/DONE, ignored.
//   - req dropped before grant: no effect. dur changes after grant: ignored.
//   - No wrap: remaining never decrements below 0. rst mid-RUN aborts silently, no done.
// CONFIGURATION
//   MORSE_TIMER_PAUSE_EN defined: pause port present; while pause=1 in RUN, ticks are
//     not counted (remaining holds); cancel still acts; IDLE arbitration unaffected.
//   Not defined: no pause port; every tick in RUN is counted.
// TESTING
//   1 Reset: rst=0 mid-RUN -> outputs 0 asynchronously, state IDLE, no done pulse.
//   2 Single: req=01, dur0=3 -> gnt=01 next cycle; 3 ticks -> done=01 one cycle after
//     3rd tick; remaining 3,2,1,0 observed.
//   3 Tie: req=11 from reset -> gnt=01; after done, req1 still held -> gnt=10; both
//     held again -> gnt=01 (round-robin alternates).
//   4 Cancel: owner 1, dur1=5, cancel=10 after 2 ticks -> IDLE, no done;
//     cancel=01 (non-owner) -> ignored; cancel with last tick -> no done.
//   5 Edge: dur0=0 -> loads 1, done after 1 tick; tick on the gnt cycle not counted.
//   6 MORSE_TIMER_PAUSE_EN: dur0=4, pause=1 across 3 ticks -> remaining holds at 4;
//     release -> done after 4 more ticks.

Source files
------------

// File: rtl/morse_timer_sched.sv
// Shared 100 ms countdown for the Morse game: round-robin grant between playback (0)
// and input window (1), counts ticks, pulses done to the owner. Option: MORSE_TIMER_PAUSE_EN.
module morse_timer_sched #(
    parameter int CNT_W = 6
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             HundredmsTimeOut,
    input  logic [1:0]       req,
    input  logic [CNT_W-1:0] dur0,
    input  logic [CNT_W-1:0] dur1,
    input  logic [1:0]       cancel,
`ifdef MORSE_TIMER_PAUSE_EN
    input  logic             pause,
`endif
    output logic [1:0]       gnt,
    output logic [1:0]       done,
    output logic             busy,
    output logic             owner,
    output logic [CNT_W-1:0] remaining
);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t           state, state_nx;
    logic             rr, rr_nx, pick, owner_nx, busy_nx;
    logic             tick_ok, cancel_hit, last_tick;
    logic [1:0]       gnt_nx, done_nx;
    logic [CNT_W-1:0] rem_nx, dsel;

    // gnt is high only on the grant cycle, so it masks the tick that arrives with it
`ifdef MORSE_TIMER_PAUSE_EN
    assign tick_ok = HundredmsTimeOut && !(|gnt) && !pause;
`else
    assign tick_ok = HundredmsTimeOut && !(|gnt);
`endif

    assign pick       = (req == 2'b11) ? rr : req[1];
    assign dsel       = pick ? dur1 : dur0;
    assign cancel_hit = cancel[owner];
    assign last_tick  = tick_ok && (remaining == CNT_W'(1));

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= IDLE;
            rr        <= 1'b0;
            gnt       <= '0;
            done      <= '0;
            busy      <= 1'b0;
            owner     <= 1'b0;
            remaining <= '0;
        end else begin
            state     <= state_nx;
            rr        <= rr_nx;
            gnt       <= gnt_nx;
            done      <= done_nx;
            busy      <= busy_nx;
            owner     <= owner_nx;
            remaining <= rem_nx;
        end
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (|req) state_nx = RUN;
            RUN:     if (cancel_hit) state_nx = IDLE;
                     else if (last_tick) state_nx = DONE;
            DONE:    state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_comb begin
        rr_nx    = rr;
        gnt_nx   = '0;
        done_nx  = '0;
        owner_nx = owner;
        rem_nx   = '0;
        busy_nx  = (state_nx != IDLE);
        case (state)
            IDLE: if (|req) begin
                gnt_nx   = pick ? 2'b10 : 2'b01;
                owner_nx = pick;
                rr_nx    = ~pick;
                rem_nx   = (dsel == '0) ? CNT_W'(1) : dsel;
            end
            RUN: begin
                rem_nx = remaining;
                if (cancel_hit)
                    rem_nx = '0;
                else if (tick_ok && remaining != '0) begin
                    rem_nx = remaining - CNT_W'(1);
                    if (last_tick) done_nx = owner ? 2'b10 : 2'b01;
                end
            end
            default: rem_nx = '0;
        endcase
    end

endmodule

// File: tb/tb_morse_timer_sched.sv
// Randomized scoreboard bench for morse_timer_sched: driver models grants/ticks at
// transaction level and queues expected gnt/done events; monitor pops on each pulse.
module tb_morse_timer_sched;

    logic       clk = 1'b0;
    logic       rst;
    logic       tick;
    logic [1:0] req, cancel;
    logic [5:0] dur0, dur1;
    logic [1:0] gnt, done;
    logic       busy, owner;
    logic [5:0] remaining;
`ifdef MORSE_TIMER_PAUSE_EN
    logic       pause;
`endif

    morse_timer_sched #(.CNT_W(6)) dut (
        .clk(clk), .rst(rst), .HundredmsTimeOut(tick), .req(req),
        .dur0(dur0), .dur1(dur1), .cancel(cancel),
`ifdef MORSE_TIMER_PAUSE_EN
        .pause(pause),
`endif
        .gnt(gnt), .done(done), .busy(busy), .owner(owner), .remaining(remaining)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit is_done;
        bit idx;
        int at;
    } ev_t;

    ev_t  q[$];
    ev_t  mon_ev;
    int   cyc = 0;
    int   total = 0;
    int   bad = 0;
    int   exp_rem = 0;
    bit   exp_busy = 0;
    bit   chk_en = 0;
    bit   rr;
    logic [1:0] pend;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input int act, input int want);
        total++;
        if (act != want) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, want, cyc);
        end
    endtask

    // Monitor: per-cycle remaining/busy plus event scoreboard on gnt/done pulses
    always @(negedge clk) begin
        if (rst && chk_en) begin
            check("remaining", remaining, exp_rem);
            check("busy", busy, exp_busy);
            if (gnt != 2'b00 || done != 2'b00) begin
                if (q.size() == 0) begin
                    check("unexpected_event", {gnt, done}, 0);
                end else begin
                    mon_ev = q.pop_front();
                    check("event_cycle", cyc, mon_ev.at);
                    if (mon_ev.is_done) begin
                        check("done", done, mon_ev.idx ? 2 : 1);
                        check("gnt_with_done", gnt, 0);
                    end else begin
                        check("gnt", gnt, mon_ev.idx ? 2 : 1);
                        check("done_with_gnt", done, 0);
                    end
                    check("owner", owner, mon_ev.idx);
                end
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push_ev(input bit is_done, input bit idx, input int at);
        ev_t e;
        e.is_done = is_done;
        e.idx     = idx;
        e.at      = at;
        q.push_back(e);
    endtask

    // One grant..done/cancel transaction; called while the DUT is visibly IDLE.
    // cmode: -1 no cancel, -2 random, >=0 cancel when that many ticks have counted.
    task automatic txn(input logic [1:0] add, input int d0, input int d1, input int cmode);
        bit w, counted, canceled, p;
        int dl, cnt, k, cancel_at;
        pend = pend | add;
        if (pend == 2'b00) pend = 2'b01;
        req    = pend;
        dur0   = 6'(d0);
        dur1   = 6'(d1);
        tick   = 1'($urandom % 2);
        cancel = 2'($urandom % 4);
        w  = (pend == 2'b11) ? rr : pend[1];
        rr = ~w;
        dl = w ? d1 : d0;
        if (dl == 0) dl = 1;
        if (cmode == -2) cancel_at = ($urandom % 4 == 0) ? int'($urandom % dl) : -1;
        else if (cmode >= dl) cancel_at = dl - 1;
        else cancel_at = cmode;
        push_ev(1'b0, w, cyc + 1);
        step();
        exp_rem  = dl;
        exp_busy = 1'b1;
        pend[w]  = 1'b0;
        req      = pend;
        dur0     = 6'($urandom);
        dur1     = 6'($urandom);
        tick     = 1'($urandom % 2);
        cancel   = ($urandom % 2 == 1) ? (w ? 2'b01 : 2'b10) : 2'b00;
        step();
        cnt = dl;
        k   = 0;
        for (int it = 0; it < 2000; it++) begin
            tick   = ($urandom % 100) < 60;
            cancel = ($urandom % 5 == 0) ? (w ? 2'b01 : 2'b10) : 2'b00;
            p      = 1'b0;
`ifdef MORSE_TIMER_PAUSE_EN
            pause = ($urandom % 4 == 0);
            p     = pause;
`endif
            canceled = (k == cancel_at);
            if (canceled) begin
                tick      = 1'b1;
                cancel[w] = 1'b1;
            end
            counted = tick && !p;
            if (!canceled && counted && cnt == 1) push_ev(1'b1, w, cyc + 1);
            step();
            if (canceled) begin
                exp_rem  = 0;
                exp_busy = 1'b0;
                break;
            end
            if (counted) begin
                cnt--;
                k++;
            end
            exp_rem = cnt;
            if (cnt == 0) begin
                exp_busy = 1'b1;
                tick     = 1'($urandom % 2);
                cancel   = 2'($urandom % 4);
                step();
                exp_busy = 1'b0;
                break;
            end
            if (it == 1999) check("run_timeout", 1, 0);
        end
        tick   = 1'b0;
        cancel = 2'b00;
`ifdef MORSE_TIMER_PAUSE_EN
        pause = 1'b0;
`endif
    endtask

    initial begin
        rst = 1'b0; tick = 1'b0; req = '0; cancel = '0; dur0 = '0; dur1 = '0;
`ifdef MORSE_TIMER_PAUSE_EN
        pause = 1'b0;
`endif
        rr = 1'b0; pend = 2'b00;
        repeat (3) step();
        check("rst_gnt", gnt, 0);
        check("rst_done", done, 0);
        check("rst_busy", busy, 0);
        check("rst_owner", owner, 0);
        check("rst_remaining", remaining, 0);
        rst = 1'b1;
        step();
        chk_en = 1'b1;

        // reset asserted mid-RUN: outputs clear at once, no done later
        req = 2'b01; dur0 = 6'd5;
        push_ev(1'b0, 1'b0, cyc + 1);
        step(); exp_rem = 5; exp_busy = 1'b1;
        req = 2'b00; step();
        tick = 1'b1; step(); exp_rem = 4;
        tick = 1'b0; step();
        chk_en = 1'b0;
        rst = 1'b0;
        #1;
        check("async_rst_busy", busy, 0);
        check("async_rst_remaining", remaining, 0);
        check("async_rst_owner", owner, 0);
        step();
        tick = 1'b1; step();
        tick = 1'b0;
        rst = 1'b1; rr = 1'b0; pend = 2'b00;
        exp_rem = 0; exp_busy = 1'b0;
        step();
        chk_en = 1'b1;

        txn(2'b01, 3, 0, -1);       // single request, 3 ticks
        txn(2'b11, 2, 4, -1);       // tie from rr=0 -> req 0
        txn(2'b00, 0, 4, -1);       // held req 1 -> granted next
        txn(2'b11, 1, 1, -1);       // tie again -> req 0
        txn(2'b00, 0, 5, 2);        // owner 1 cancelled after 2 ticks
        txn(2'b01, 0, 0, -1);       // zero duration loads 1
        txn(2'b01, 3, 0, 2);        // cancel together with final tick
        repeat (4) step();

        for (int n = 0; n < 150; n++) begin
            if (pend == 2'b00) begin
                repeat ($urandom % 3) begin
                    tick = 1'($urandom % 2);
                    cancel = 2'($urandom % 4);
                    step();
                end
            end
            txn(2'($urandom % 4), ($urandom % 8 == 0) ? 63 : int'($urandom % 9),
                int'($urandom % 9), -2);
        end
        repeat (3) step();
        check("queue_empty", q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #3_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1);
    end

endmodule
